// File: rtl/threewire_pkg.sv
// ============================================================================
// threewire_pkg : shared widths, FSM encoding and sizing helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package threewire_pkg;

    localparam int DEF_ADDR_BITS = 10;
    localparam int DEF_DATA_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter only has to reach START_TIMEOUT-1.
    function automatic int cnt_width(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/threewire_arbiter_picker.sv
// ============================================================================
// rr_priority_picker : first asserted request after last_grant, wrapping
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker
    import threewire_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    // Scan from the farthest offset down so the nearest one after i_last wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = (int'(i_last) + k) % NUM_REQ;
            if (i_req[w_cand[IDX_W-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/threewire_arbiter.sv
// ============================================================================
// threewire_arbiter : round-robin sequencer sharing one threewire master
// Rev 1.0
// ============================================================================
`default_nettype none

module threewire_arbiter
    import threewire_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int START_TIMEOUT = 255
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic [NUM_REQ-1:0]             in_req,
    input  logic [NUM_REQ-1:0]             in_req_mode_wr,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   in_req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   in_req_wr_data,
    output logic [NUM_REQ-1:0]             out_req_ack,
    output logic [NUM_REQ-1:0]             out_req_done,
    output logic [NUM_REQ-1:0]             out_req_err,
    output logic [DATA_BITS-1:0]           out_rd_data,
    output logic                           out_busy,
    output logic                           out_tw_start,
    output logic                           out_tw_mode_wr,
    output logic [ADDR_BITS-1:0]           out_tw_addr,
    output logic [DATA_BITS-1:0]           out_tw_wr_data,
    input  logic                           in_tw_in_progress,
    input  logic [DATA_BITS-1:0]           in_tw_rd_data
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(START_TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_valid;
    logic [IDX_W-1:0]   w_pick;
    logic [NUM_REQ-1:0] w_pick_oh;
    logic [NUM_REQ-1:0] w_grant_oh;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (in_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    assign w_pick_oh  = NUM_REQ'(1) << w_pick;
    assign w_grant_oh = NUM_REQ'(1) << r_grant;

    // Pulses are loaded on the edge entering the state they belong to so that
    // every output comes straight from a flop.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state        <= ST_IDLE;
            r_last         <= C_LAST_RST;
            r_grant        <= '0;
            r_cnt          <= '0;
            out_req_ack    <= '0;
            out_req_done   <= '0;
            out_req_err    <= '0;
            out_rd_data    <= '0;
            out_busy       <= 1'b0;
            out_tw_start   <= 1'b0;
            out_tw_mode_wr <= 1'b0;
            out_tw_addr    <= '0;
            out_tw_wr_data <= '0;
        end else begin
            out_req_ack  <= '0;
            out_req_done <= '0;
            out_req_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_state        <= ST_START;
                        r_grant        <= w_pick;
                        r_last         <= w_pick;
                        r_cnt          <= '0;
                        out_tw_mode_wr <= in_req_mode_wr[w_pick];
                        out_tw_addr    <= in_req_addr[w_pick*ADDR_BITS +: ADDR_BITS];
                        out_tw_wr_data <= in_req_wr_data[w_pick*DATA_BITS +: DATA_BITS];
                        out_req_ack    <= w_pick_oh;
                        out_tw_start   <= 1'b1;
                        out_busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (in_tw_in_progress) begin
                        r_state      <= ST_XFER;
                        out_tw_start <= 1'b0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state      <= ST_ERR;
                        out_tw_start <= 1'b0;
                        out_req_done <= w_grant_oh;
                        out_req_err  <= w_grant_oh;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_XFER: begin
                    if (!in_tw_in_progress) begin
                        r_state      <= ST_DONE;
                        out_req_done <= w_grant_oh;
                        if (!out_tw_mode_wr) begin
                            out_rd_data <= in_tw_rd_data;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state  <= ST_IDLE;
                    out_busy <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/threewire_arbiter.md
# threewire_arbiter

Round-robin arbiter and sequencer that shares one `threewire` master among `NUM_REQ` requesters. Each requester presents a read or write command and holds it until the arbiter accepts it. The arbiter issues the command to the master, waits for the serial transfer to finish, and returns completion and read data to the granted requester. It sits between the register-access clients and the single `threewire` instance, on the same clock.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_BITS`, 10: address width, equal to the master's `ADDR_BITS`.
- `DATA_BITS`, 32: data width, equal to the master's `DATA_BITS`.
- `START_TIMEOUT`, 255: maximum cycles to wait for the master to acknowledge start, ≥1.

Ports:
- `in_clk` in 1: system clock, shared with the master.
- `in_rst` in 1: reset, asynchronous, active-high.
- `in_req` in NUM_REQ: per-requester request, level.
- `in_req_mode_wr` in NUM_REQ: 1 = write, 0 = read.
- `in_req_addr` in NUM_REQ*ADDR_BITS: packed addresses, requester i at `[i*ADDR_BITS +: ADDR_BITS]`.
- `in_req_wr_data` in NUM_REQ*DATA_BITS: packed write data, same packing.
- `out_req_ack` out NUM_REQ: one-cycle pulse, command accepted.
- `out_req_done` out NUM_REQ: one-cycle pulse, transfer finished.
- `out_req_err` out NUM_REQ: one-cycle pulse with done, start timeout.
- `out_rd_data` out DATA_BITS: data of the last successful read.
- `out_busy` out 1: high whenever state ≠ IDLE.
- `out_tw_start`, `out_tw_mode_wr` out 1: to master `in_start` / `in_mode_wr`.
- `out_tw_addr` out ADDR_BITS; `out_tw_wr_data` out DATA_BITS: to the master.
- `in_tw_in_progress` in 1; `in_tw_rd_data` in DATA_BITS: from master `out_io_in_progress` / `out_rd_data`.

## Operation
- **Requester handshake:** hold `in_req[i]` high and fields stable until `out_req_ack[i]`. Fields may then change. Dropping `in_req` before ack is legal; the arbiter simply never serves it.
- **Arbitration:** round-robin only.
  - In IDLE, search starts at `last_grant+1` mod NUM_REQ. The first asserted request wins.
  - `last_grant` updates on each grant. After reset it is NUM_REQ-1, so requester 0 has first priority.
- **State machine:**
  - IDLE: if any `in_req` is high → START. Latch the winner's mode, address and write data into command registers. Set the grant index. Pulse `out_req_ack[g]`. Clear the timeout counter.
  - START: `out_tw_start`=1.
    - If `in_tw_in_progress`=1 → XFER, with start deasserted.
    - Else if counter = START_TIMEOUT-1 → ERR.
    - Else increment the counter.
  - XFER: wait for `in_tw_in_progress`=0 → DONE.
  - DONE: pulse `out_req_done[g]`. For a read, register `in_tw_rd_data` into `out_rd_data`. Go to IDLE.
  - ERR: pulse `out_req_done[g]` and `out_req_err[g]`. `out_rd_data` is unchanged. Go to IDLE.
- **Command outputs:** `out_tw_mode_wr`, `out_tw_addr` and `out_tw_wr_data` come from the command registers and stay stable from START through DONE/ERR.
- **Read data:** `out_rd_data` is unchanged by writes and by errors.
- **All outputs are registered.** Reset values:
  - State = IDLE.
  - All pulses, `out_tw_start` and `out_busy` = 0.
  - Command registers and `out_rd_data` = 0.
  - `last_grant` = NUM_REQ-1.

## Timing
- **Request to ack:** a request sampled in IDLE at edge k gives `out_req_ack` and `out_tw_start` high during cycle k+1.
- **Start deassertion:** `out_tw_start` drops on the edge after `in_tw_in_progress` is first seen high.
- **Done:** `out_req_done` is high for the one cycle following the first low sample of `in_tw_in_progress` in XFER. `out_rd_data` is valid in that same cycle.
- **Issue rate:** minimum one IDLE cycle between consecutive commands. With back-to-back pending requests, the next ack comes 1 cycle after done.
- **Simultaneous requests:** exactly one grant. Others wait, with no starvation. Worst-case wait is NUM_REQ-1 transfers.
- **Timeout:** ERR is entered START_TIMEOUT cycles after entering START.
- **Reset mid-transfer:** immediate return to reset values. No done or err pulse for the aborted command. The master shares `in_rst`, so the bus chip select is released by the master itself.
- **Stale busy:** `in_tw_in_progress` high while IDLE is ignored.

## Structure
- Package `threewire_pkg`:
  - default ADDR_BITS/DATA_BITS;
  - state encoding IDLE/START/XFER/DONE/ERR (3 bits);
  - `clog2`-based index and timeout counter width helpers.
- Sub-module `rr_priority_picker`: combinational. Inputs: request vector and `last_grant`. Outputs: `valid` and the winner index. Instantiated once.

## Test plan
- **Single read:** requester 0 reads addr 10'h333; slave returns 32'hAABBCCDD. Expect ack at +1 cycle, `out_req_done[0]` once, `out_rd_data`=32'hAABBCCDD, slave saw mode 0 and addr 10'h333.
- **Single write:** requester 2 writes 32'h00112233 to 10'h2AA. Expect slave `wr_data`=32'h00112233, addr 10'h2AA, `out_rd_data` unchanged.
- **Round-robin fairness:** all 4 requesters hold reads continuously. Expect grant order 0,1,2,3,0 and exactly one ack per transfer.
- **Timeout:** `in_tw_in_progress` forced 0, START_TIMEOUT=8. Expect `out_req_done[g]` and `out_req_err[g]` 8 cycles after ack, then IDLE.
- **Async reset mid-XFER:** assert `in_rst` during a write. Expect all outputs zero immediately, no done pulse, and requester 0 granted first after release.
- **Late drop:** requester 1 drops `in_req` before sampling while requester 3 holds its request. Expect only requester 3 served.
